ila_fifo_readout: RTL and testbench

- Read-side drain stage for the cascaded capture FIFO in the ILA storage path.
- On a host readout request, pops a programmed number of samples from the FIFO and compensates for the FIFO's registered read latency.
- Each WIDTH-bit sample is serialised into bytes on a valid/ready byte stream feeding the host-link transmitter.
- Runs entirely in the FIFO read clock domain.

---
 rtl/ila_fifo_readout.sv | 125 ++++++++++++
 tb/tb_ila_fifo_readout.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ila_fifo_readout.sv
// ILA capture FIFO read-side drain: pops samples, absorbs the FIFO read
// latency and serialises each sample LSB byte first onto a byte stream.
module ila_fifo_readout #(
   parameter int WIDTH      = 20,
   parameter int RD_LATENCY = 2,
   parameter int CNT_W      = 16
) (
   input  logic             rclk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [CNT_W-1:0] sample_count_i,
   input  logic             fifo_empty_i,
   output logic             fifo_pop_o,
   input  logic [WIDTH-1:0] fifo_do_i,
   output logic [7:0]       tx_data_o,
   output logic             tx_valid_o,
   input  logic             tx_ready_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             underrun_o
);

   localparam int NBYTES = (WIDTH + 7) / 8;
   localparam int SR_W   = NBYTES * 8;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int LAT_W  = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_WAIT,
      S_SEND,
      S_FIN
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [SR_W-1:0]  sr_q, sr_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic             under_q, under_d;
   logic             pop;

   always_ff @(posedge rclk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         sr_q    <= '0;
         idx_q   <= '0;
         lat_q   <= '0;
         under_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         sr_q    <= sr_d;
         idx_q   <= idx_d;
         lat_q   <= lat_d;
         under_q <= under_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      sr_d    = sr_q;
      idx_d   = idx_q;
      lat_d   = lat_q;
      under_d = under_q;
      pop     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               rem_d   = sample_count_i;
               under_d = 1'b0;
               state_d = (sample_count_i == '0) ? S_FIN : S_POP;
            end
         end
         S_POP: begin
            // never pop an empty FIFO; owing samples with none left is an underrun
            if (!fifo_empty_i) begin
               pop     = 1'b1;
               lat_d   = '0;
               state_d = S_WAIT;
            end else begin
               under_d = 1'b1;
               state_d = S_FIN;
            end
         end
         S_WAIT: begin
            if (lat_q == LAT_W'(RD_LATENCY - 1)) begin
               sr_d    = SR_W'(fifo_do_i);
               idx_d   = '0;
               state_d = S_SEND;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         S_SEND: begin
            if (tx_ready_i) begin
               if (idx_q != IDX_W'(NBYTES - 1)) begin
                  idx_d = idx_q + 1'b1;
                  sr_d  = sr_q >> 8;
               end else begin
                  if (rem_q != '0) rem_d = rem_q - 1'b1;
                  state_d = (rem_q <= CNT_W'(1)) ? S_FIN : S_POP;
               end
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign fifo_pop_o = pop;
   assign tx_valid_o = (state_q == S_SEND);
   assign tx_data_o  = sr_q[7:0];
   assign busy_o     = (state_q != S_IDLE);
   assign done_o     = (state_q == S_FIN);
   assign underrun_o = under_q;

endmodule

// File: tb/tb_ila_fifo_readout.sv
// Bench for ila_fifo_readout: three instances (RD_LATENCY 2,1,3), each fed
// by a model FIFO with matching read latency; bytes checked against samples.
`timescale 1ns/1ps
module tb_ila_fifo_readout;

   localparam int W  = 20;
   localparam int NI = 3;

   logic          rclk = 1'b0;
   logic          rst;
   logic          start [NI];
   logic [15:0]   cnt   [NI];
   logic          empty [NI];
   logic          pop   [NI];
   logic [W-1:0]  dout  [NI];
   logic [7:0]    txd   [NI];
   logic          txv   [NI];
   logic          rdy   [NI];
   logic          busy  [NI];
   logic          done  [NI];
   logic          und   [NI];

   logic [W-1:0]  mem   [NI][64];
   logic [W-1:0]  pipe  [NI][4];
   int            wr_ptr [NI] = '{0, 0, 0};
   int            rd_ptr [NI] = '{0, 0, 0};
   int            pops   [NI] = '{0, 0, 0};
   int            dones  [NI] = '{0, 0, 0};
   int            ev     [NI] = '{0, 0, 0};
   int            sv     [NI] = '{0, 0, 0};
   int            rxn    [NI] = '{0, 0, 0};
   logic          pend   [NI] = '{0, 0, 0};
   logic [7:0]    pend_d [NI];
   logic [7:0]    rxbuf  [NI][512];
   int            cyc = 0;

   int            checks = 0;
   int            errors = 0;
   logic [W-1:0]  exp_s[$];

   int o_ts, o_tv, o_td, o_r0;
   int o_pops, o_dones, o_nb, o_sv, o_ev;
   bit o_fin;

   always #5 rclk = ~rclk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
      assign empty[g] = (wr_ptr[g] == rd_ptr[g]);
      assign dout[g]  = pipe[g][L-1];
      ila_fifo_readout #(
         .WIDTH(W), .RD_LATENCY(L), .CNT_W(16)
      ) u_dut (
         .rclk(rclk), .rst(rst),
         .start_i(start[g]), .sample_count_i(cnt[g]),
         .fifo_empty_i(empty[g]), .fifo_pop_o(pop[g]),
         .fifo_do_i(dout[g]),
         .tx_data_o(txd[g]), .tx_valid_o(txv[g]),
         .tx_ready_i(rdy[g]),
         .busy_o(busy[g]), .done_o(done[g]),
         .underrun_o(und[g])
      );
   end

   // model FIFO with registered read latency plus stream monitors
   always @(posedge rclk) begin
      cyc <= cyc + 1;
      for (int g = 0; g < NI; g++) begin
         for (int k = 3; k > 0; k--) pipe[g][k] <= pipe[g][k-1];
         pipe[g][0] <= W'($urandom);
         if (pop[g]) begin
            pops[g] <= pops[g] + 1;
            if (empty[g]) ev[g] <= ev[g] + 1;
            else begin
               pipe[g][0] <= mem[g][rd_ptr[g] % 64];
               rd_ptr[g]  <= rd_ptr[g] + 1;
            end
         end
         if (done[g]) dones[g] <= dones[g] + 1;
         if (txv[g] && rdy[g]) begin
            rxbuf[g][rxn[g] % 512] <= txd[g];
            rxn[g] <= rxn[g] + 1;
         end
         if (rst) pend[g] <= 1'b0;
         else begin
            if (pend[g] && (!txv[g] || txd[g] !== pend_d[g]))
               sv[g] <= sv[g] + 1;
            pend[g]   <= txv[g] && !rdy[g];
            pend_d[g] <= txd[g];
         end
      end
   end

   function automatic int lat_of(input int g);
      return (g == 0) ? 2 : ((g == 1) ? 1 : 3);
   endfunction

   function automatic logic [7:0] exp_byte(input int i);
      logic [23:0] w;
      w = 24'(exp_s[i / 3]);
      return w[8*(i % 3) +: 8];
   endfunction

   function automatic int bytes_bad(input int g, input int n);
      int bad = 0;
      for (int i = 0; i < n; i++)
         if (rxbuf[g][(o_r0 + i) % 512] !== exp_byte(i)) bad++;
      return bad;
   endfunction

   task automatic flush(input int g);
      exp_s.delete();
      wr_ptr[g] = rd_ptr[g];
   endtask

   task automatic push(input int g, input logic [W-1:0] v);
      mem[g][wr_ptr[g] % 64] = v;
      wr_ptr[g] = wr_ptr[g] + 1;
      exp_s.push_back(v);
   endtask

   task automatic consume(input int n);
      for (int i = 0; i < n && exp_s.size() > 0; i++) void'(exp_s.pop_front());
   endtask

   task automatic drive(input int g, input int count, input int mode, input bit ign);
      int p0, d0, r0, s0, e0;
      p0 = pops[g]; d0 = dones[g]; r0 = rxn[g]; s0 = sv[g]; e0 = ev[g];
      o_tv = -1; o_td = -1; o_fin = 0; o_r0 = r0;
      @(negedge rclk);
      start[g] = 1'b1;
      cnt[g]   = 16'(count);
      rdy[g]   = (mode != 1);
      o_ts     = cyc;
      @(negedge rclk);
      start[g] = 1'b0;
      cnt[g]   = 16'($urandom);
      for (int c = 0; c < 3000; c++) begin
         if (txv[g] && o_tv < 0) o_tv = cyc;
         if (done[g]) begin
            o_td = cyc; o_fin = 1; break;
         end
         case (mode)
            0:       rdy[g] = 1'b1;
            1:       rdy[g] = (c % 3 == 2);
            default: rdy[g] = 1'($urandom_range(0, 1));
         endcase
         start[g] = ign && (c == 3);
         if (ign && c == 3) cnt[g] = 16'd7;
         @(negedge rclk);
      end
      start[g] = 1'b0;
      rdy[g]   = 1'b0;
      repeat (3) @(negedge rclk);
      o_pops  = pops[g] - p0;
      o_dones = dones[g] - d0;
      o_nb    = rxn[g] - r0;
      o_sv    = sv[g] - s0;
      o_ev    = ev[g] - e0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge rclk);
      for (int g = 0; g < NI; g++) begin
         checks++;
         if ({pop[g], txv[g], txd[g], busy[g], done[g], und[g]} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs[%0d] got %b expected 0", g,
                     {pop[g], txv[g], txd[g], busy[g], done[g], und[g]});
         end
      end
      rst = 1'b0;
      @(negedge rclk);
   endtask

   task automatic test_basic();
      logic [7:0] e [6] = '{8'h45, 8'h23, 8'h01, 8'hDE, 8'hBC, 8'h0A};
      int bad = 0;
      flush(0);
      push(0, 20'h12345);
      push(0, 20'hABCDE);
      drive(0, 2, 0, 0);
      checks++;
      if (!o_fin) begin errors++; $display("FAIL basic_timeout got no done expected done"); end
      checks++;
      if (o_pops !== 2) begin errors++; $display("FAIL basic_pops got %0d expected 2", o_pops); end
      checks++;
      if (o_nb !== 6) begin errors++; $display("FAIL basic_nbytes got %0d expected 6", o_nb); end
      for (int i = 0; i < 6; i++) if (rxbuf[0][(o_r0 + i) % 512] !== e[i]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL basic_bytes got %0d bad bytes expected 0", bad); end
      checks++;
      if (o_dones !== 1) begin errors++; $display("FAIL basic_done got %0d expected 1", o_dones); end
      checks++;
      if (und[0] !== 1'b0) begin errors++; $display("FAIL basic_underrun got %b expected 0", und[0]); end
      checks++;
      if (o_tv - o_ts !== 4) begin errors++; $display("FAIL basic_latency got %0d expected 4", o_tv - o_ts); end
      consume(2);
   endtask

   task automatic test_backpressure();
      logic [7:0] e [3] = '{8'hFF, 8'hFF, 8'h0F};
      int bad = 0;
      flush(0);
      push(0, 20'hFFFFF);
      drive(0, 1, 1, 0);
      for (int i = 0; i < 3; i++) if (rxbuf[0][(o_r0 + i) % 512] !== e[i]) bad++;
      checks++;
      if (o_nb !== 3 || bad != 0) begin
         errors++; $display("FAIL bp_bytes got n=%0d bad=%0d expected n=3 bad=0", o_nb, bad);
      end
      checks++;
      if (o_sv !== 0) begin errors++; $display("FAIL bp_stable got %0d violations expected 0", o_sv); end
      checks++;
      if (o_pops !== 1) begin errors++; $display("FAIL bp_pops got %0d expected 1", o_pops); end
      checks++;
      if (o_dones !== 1) begin errors++; $display("FAIL bp_done got %0d expected 1", o_dones); end
      consume(1);
   endtask

   task automatic test_underrun();
      flush(0);
      push(0, W'($urandom));
      drive(0, 3, 0, 0);
      checks++;
      if (o_pops !== 1) begin errors++; $display("FAIL ur_pops got %0d expected 1", o_pops); end
      checks++;
      if (o_nb !== 3 || bytes_bad(0, 3) != 0) begin
         errors++; $display("FAIL ur_bytes got n=%0d expected 3 matching", o_nb);
      end
      checks++;
      if (und[0] !== 1'b1) begin errors++; $display("FAIL ur_flag got %b expected 1", und[0]); end
      checks++;
      if (o_ev !== 0) begin errors++; $display("FAIL ur_pop_empty got %0d expected 0", o_ev); end
      checks++;
      if (o_dones !== 1) begin errors++; $display("FAIL ur_done got %0d expected 1", o_dones); end
      consume(1);
   endtask

   task automatic test_zero_and_ignored();
      flush(0);
      drive(0, 0, 0, 0);
      checks++;
      if (o_td - o_ts !== 1 || o_dones !== 1) begin
         errors++; $display("FAIL zero_done got dt=%0d n=%0d expected dt=1 n=1", o_td - o_ts, o_dones);
      end
      checks++;
      if (o_pops !== 0) begin errors++; $display("FAIL zero_pops got %0d expected 0", o_pops); end
      checks++;
      if (und[0] !== 1'b0) begin errors++; $display("FAIL zero_underrun_clear got %b expected 0", und[0]); end
      for (int i = 0; i < 4; i++) push(0, W'($urandom));
      drive(0, 2, 0, 1);
      checks++;
      if (o_pops !== 2 || o_nb !== 6) begin
         errors++; $display("FAIL ignored_start got pops=%0d n=%0d expected 2 6", o_pops, o_nb);
      end
      checks++;
      if (bytes_bad(0, 6) != 0 || o_dones !== 1) begin
         errors++; $display("FAIL ignored_bytes got dones=%0d expected 1 and matching bytes", o_dones);
      end
      flush(0);
   endtask

   task automatic test_latency();
      for (int g = 1; g < NI; g++) begin
         flush(g);
         push(g, W'($urandom));
         drive(g, 1, 0, 0);
         checks++;
         if (o_tv - o_ts !== 2 + lat_of(g)) begin
            errors++; $display("FAIL lat%0d_first_valid got %0d expected %0d", lat_of(g), o_tv - o_ts, 2 + lat_of(g));
         end
         checks++;
         if (o_nb !== 3 || bytes_bad(g, 3) != 0 || o_pops !== 1) begin
            errors++; $display("FAIL lat%0d_capture got n=%0d pops=%0d expected 3 1", lat_of(g), o_nb, o_pops);
         end
         flush(g);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 9; it++) begin
         int g, n, c, ne;
         g = it % NI;
         n = $urandom_range(0, 5);
         c = $urandom_range(0, 6);
         flush(g);
         for (int i = 0; i < n; i++) push(g, W'($urandom));
         ne = (c < n) ? c : n;
         drive(g, c, 2, 0);
         checks++;
         if (o_pops !== ne || o_nb !== 3 * ne || bytes_bad(g, 3 * ne) != 0) begin
            errors++; $display("FAIL rand%0d_data got pops=%0d n=%0d expected pops=%0d", it, o_pops, o_nb, ne);
         end
         checks++;
         if (und[g] !== (c > n) || o_dones !== 1 || o_sv !== 0 || o_ev !== 0) begin
            errors++; $display("FAIL rand%0d_status got und=%b dones=%0d sv=%0d ev=%0d expected und=%b 1 0 0",
                               it, und[g], o_dones, o_sv, o_ev, (c > n));
         end
         flush(g);
      end
   endtask

   task automatic test_reset_mid();
      int r0, d0;
      bit seen = 0;
      flush(0);
      for (int i = 0; i < 3; i++) push(0, W'($urandom));
      @(negedge rclk);
      start[0] = 1'b1; cnt[0] = 16'd2; rdy[0] = 1'b1;
      r0 = rxn[0];
      @(negedge rclk);
      start[0] = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge rclk);
         if (rxn[0] - r0 >= 1) seen = 1;
      end
      rdy[0] = 1'b0;
      checks++;
      if (!seen) begin errors++; $display("FAIL rstmid_timeout got no byte expected 1 byte"); end
      d0 = dones[0];
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({pop[0], txv[0], txd[0], busy[0], done[0], und[0]} !== 13'd0) begin
         errors++; $display("FAIL rstmid_outputs got %b expected 0",
                            {pop[0], txv[0], txd[0], busy[0], done[0], und[0]});
      end
      repeat (3) @(negedge rclk);
      rst = 1'b0;
      repeat (2) @(negedge rclk);
      checks++;
      if (dones[0] - d0 !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d expected 0", dones[0] - d0); end
      consume(1);
      drive(0, 2, 0, 0);
      checks++;
      if (o_pops !== 2 || o_nb !== 6 || bytes_bad(0, 6) != 0 || o_dones !== 1) begin
         errors++; $display("FAIL rstmid_redrain got pops=%0d n=%0d dones=%0d expected 2 6 1", o_pops, o_nb, o_dones);
      end
      flush(0);
   endtask

   initial begin
      for (int g = 0; g < NI; g++) begin
         start[g] = 1'b0; cnt[g] = '0; rdy[g] = 1'b0;
      end
      test_reset();
      test_basic();
      test_backpressure();
      test_underrun();
      test_zero_and_ignored();
      test_latency();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
